// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: bitwise AND/OR/XOR/NAND of two operands, results queued in a DEPTH-entry FIFO.
// Latency: a result pushed into an empty FIFO is visible on out1 the cycle after the push edge.
// Backpressure: in_ready = occupancy < DEPTH (registered only); a full FIFO stalls the producer.
// Optional: define GATE_UNIT_POPCOUNT_EN to add out_ones (count of set bits stored with each result).
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in1,
  input  logic [WIDTH-1:0]             in2,
  input  logic [1:0]                   op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out1,
  output logic [CNT_W-1:0]             ops_cnt
`ifdef GATE_UNIT_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  // Operation select; all four encodings are legal.
  always_comb begin
    result = '0;
    case (op)
      2'b00:   result = in1 & in2;
      2'b01:   result = in1 | in2;
      2'b10:   result = in1 ^ in2;
      default: result = ~(in1 & in2);
    endcase
  end

  // Handshakes come from occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (occ != OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is gated so out1 reads 0 whenever the FIFO is empty (including after reset).
  assign out1 = out_valid ? mem[rd_ptr] : '0;

  // Result storage; contents need no reset because empty entries are never exposed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  // Pointers, occupancy and consumed-results counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      ops_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        ops_cnt <= ops_cnt + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef GATE_UNIT_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH+1);

  logic [ONES_W-1:0] ones_mem [DEPTH];
  logic [ONES_W-1:0] ones;

  // Population count of the result being pushed.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + ONES_W'(result[i]);
    end
  end

  // Count is stored beside its result so it follows the same FIFO order.
  always_ff @(posedge clk) begin
    if (push) begin
      ones_mem[wr_ptr] <= ones;
    end
  end

  assign out_ones = out_valid ? ones_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Self-checking bench for gate_unit_pipe: queue-based reference model plus directed literal checks.
module tb_gate_unit_pipe;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in1, in2, out1;
  logic [1:0]   op;
  logic [CW-1:0] ops_cnt;

  logic         w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
  logic [0:0]   w1_in1, w1_in2, w1_out1;
  logic [1:0]   w1_op;
  logic [7:0]   w1_ops_cnt;

`ifdef GATE_UNIT_POPCOUNT_EN
  logic [3:0]   out_ones;
  logic [0:0]   w1_out_ones;
`endif

  gate_unit_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .ops_cnt(ops_cnt)
`ifdef GATE_UNIT_POPCOUNT_EN
    , .out_ones(out_ones)
`endif
  );

  gate_unit_pipe #(.WIDTH(1), .DEPTH(4), .CNT_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in1(w1_in1), .in2(w1_in2), .op(w1_op),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready),
    .out1(w1_out1), .ops_cnt(w1_ops_cnt)
`ifdef GATE_UNIT_POPCOUNT_EN
    , .out_ones(w1_out_ones)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  logic [W-1:0] mq[$];
  int           m_cnt = 0;
  logic [W-1:0] obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Reference model: transaction-level queue updated from the bench's own inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
        mq.delete();
        m_cnt = 0;
      end else begin
        bit pu, po;
        pu = in_valid && (mq.size() < D);
        po = (mq.size() > 0) && out_ready;
        if (po) begin
          void'(mq.pop_front());
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
        if (pu) mq.push_back(gate(op, in1, in2));
      end
    end
  end

  // Every-cycle comparison against the model, and log of values actually consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("in_ready", in_ready, (mq.size() < D));
        chk("out_valid", out_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
          chk("out1", out1, mq[0]);
`ifdef GATE_UNIT_POPCOUNT_EN
          chk("out_ones", out_ones, $countones(mq[0]));
`endif
        end
        chk("ops_cnt", ops_cnt, m_cnt);
        if (out_valid && out_ready) obs.push_back(out1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
    logic acc;
    acc = 1'b0;
    in1 = a; in2 = b; op = o; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready;
      step();
      if (acc) break;
    end
    chk("push_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [W-1:0] exp);
    if (idx < obs.size()) chk(name, obs[idx], exp);
    else chk(name, 32'hDEAD, exp);
  endtask

  initial begin
    logic [W-1:0] exp_ops [4];
    logic [0:0]   exp_tt  [4];
    int b;
    exp_ops = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    exp_tt  = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0; op = '0;
    w1_in_valid = 1'b0; w1_out_ready = 1'b0; w1_in1 = '0; w1_in2 = '0; w1_op = '0;

    // Reset state
    step(); step();
    started = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ops_cnt", ops_cnt, 0);
    chk("rst_out1", out1, 0);
    chk("rst_w1_out_valid", w1_out_valid, 1'b0);
    rst_n = 1'b1;
    step();

    // WIDTH=1 AND truth table, one result per cycle
    w1_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] iv;
      iv = 2'(i);
      w1_in1 = iv[1]; w1_in2 = iv[0]; w1_op = 2'b00; w1_in_valid = 1'b1;
      step();
      chk("tt_valid", w1_out_valid, 1'b1);
      chk("tt_out1", w1_out1, exp_tt[i]);
    end
    w1_in_valid = 1'b0;
    step(); step();
    chk("tt_ops_cnt", w1_ops_cnt, 4);
    chk("tt_drained", w1_out_valid, 1'b0);

    // All four ops on F0/3C
    out_ready = 1'b1;
    b = obs.size();
    for (int o = 0; o < 4; o++) push_one(8'hF0, 8'h3C, 2'(o));
    repeat (3) step();
    for (int k = 0; k < 4; k++) chk_obs("ops_result", b + k, exp_ops[k]);
    chk("ops_cnt_after_ops", ops_cnt, 4);

    // Backpressure: 5 pushes into a 4-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    b = obs.size();
    for (int i = 0; i < 4; i++) push_one(8'(8'h11 * (i + 1)), 8'hFF, 2'b00);
    chk("full_in_ready", in_ready, 1'b0);
    in1 = 8'h55; in2 = 8'hFF; op = 2'b00; in_valid = 1'b1;
    repeat (3) step();
    chk("held_in_ready", in_ready, 1'b0);
    chk("held_out1", out1, 8'h11);
    out_ready = 1'b1;
    begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 20; k++) begin
        acc = in_ready;
        step();
        if (acc) break;
      end
      chk("fifth_accept", acc, 1'b1);
    end
    in_valid = 1'b0;
    repeat (8) step();
    for (int k = 0; k < 5; k++) chk_obs("bp_order", b + k, 8'(8'h11 * (k + 1)));
    chk("bp_ops_cnt", ops_cnt, 9);

    // Simultaneous push/pop holding occupancy at 2
    out_ready = 1'b0;
    b = obs.size();
    push_one(8'h60, 8'h00, 2'b01);
    push_one(8'h61, 8'h00, 2'b01);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in1 = 8'(8'h62 + i); in2 = 8'h00; op = 2'b01; in_valid = 1'b1;
      step();
      chk("occ_steady", u_dut.occ, 2);
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("pp_count", obs.size(), b + 12);
    for (int k = 0; k < 12; k++) chk_obs("pp_order", b + k, 8'(8'h60 + k));
    chk("pp_ops_cnt", ops_cnt, 5);

    // Counter wrap: 17 results consumed with a 4-bit counter
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("wrap_start", ops_cnt, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_one(8'(i), 8'hFF, 2'b00);
    repeat (3) step();
    chk("wrap_ops_cnt", ops_cnt, 1);

    // Reset mid-operation with 3 entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(8'(8'hA0 + i), 8'hFF, 2'b00);
    in1 = 8'hEE; in2 = 8'hEE; op = 2'b01; in_valid = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_ops_cnt", ops_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    b = obs.size();
    out_ready = 1'b1;
    push_one(8'h5A, 8'h0F, 2'b10);
    repeat (3) step();
    chk("mid_rst_count", obs.size(), b + 1);
    chk_obs("mid_rst_value", b, 8'h55);
    chk("mid_rst_ops_cnt_after", ops_cnt, 1);

`ifdef GATE_UNIT_POPCOUNT_EN
    out_ready = 1'b0;
    push_one(8'hFF, 8'h0F, 2'b10);
    chk("pc_out1", out1, 8'hF0);
    chk("pc_out_ones", out_ones, 4);
    out_ready = 1'b1;
    repeat (3) step();
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_unit_pipe.md
Name: gate_unit_pipe

Overview:
Parametrised, registered successor to the single-bit 2-input AND gate. Applies a selectable bitwise operation (AND/OR/XOR/NAND) to two WIDTH-bit operands and queues each result in a DEPTH-entry output FIFO. The FIFO uses valid/ready handshakes on both sides. A wrapping counter reports how many results the downstream side has consumed. Sits between an operand producer and any consumer that can stall.

Parameters:
WIDTH, 8, operand/result bit width (>=1)
DEPTH, 4, result FIFO entries (power of two, >=2)
CNT_W, 8, width of the consumed-results counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  operands and op are valid
in_ready  out  1  block can accept operands this cycle
in1  in  WIDTH  operand A
in2  in  WIDTH  operand B
op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
out_valid  out  1  FIFO head holds a result
out_ready  in  1  consumer accepts head this cycle
out1  out  WIDTH  result at FIFO head
ops_cnt  out  CNT_W  number of results consumed, modulo 2^CNT_W

Behaviour:
- Reset: one clock, synchronous, active-low. Sampled on the clk rising edge while rst_n=0.
  - Clears FIFO pointers, occupancy, out1 (0) and ops_cnt (0).
  - out_valid=0. in_ready=1 once occupancy is clear.
  - in_valid and out_ready are ignored while rst_n=0.
- Push: occurs when in_valid && in_ready at a rising edge.
  - The result op(in1,in2) is computed combinationally.
  - It is written into the FIFO at the tail.
  - op, in1 and in2 are sampled only on the push edge.
- Pop: occurs when out_valid && out_ready at a rising edge.
  - The head entry is removed.
  - ops_cnt increments by 1 and wraps from 2^CNT_W-1 to 0 without a flag.
- Latency: a result pushed into an empty FIFO appears on out1 with out_valid=1 in the cycle after the push edge.
- Handshake outputs:
  - in_ready = (occupancy < DEPTH). It is derived from registers only; there is no combinational path from out_ready.
  - out_valid = (occupancy > 0).
  - out1 is the FIFO head. It holds stable while out_valid && !out_ready.
  - out1 is don't-care when out_valid=0, but is driven 0 after reset.
- Occupancy counter: range 0..DEPTH, width $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Boundary conditions:
  - Full (occupancy=DEPTH): in_ready=0. A simultaneous pop frees one slot, and in_ready=1 on the next cycle.
  - Empty: out_valid=0. A push and a pop cannot coincide.
  - Push and pop on the same edge with 0<occupancy<DEPTH: occupancy is unchanged, and the head advances to the next entry.
  - Reset mid-operation: all queued results are discarded. ops_cnt returns to 0, and no partial result is emitted.
- Operation encoding: NAND = ~(in1 & in2), applied bitwise across all WIDTH bits. op values are exhaustive, so there is no illegal op.

Optional Feature:
- Macro: GATE_UNIT_POPCOUNT_EN.
- When defined:
  - Adds output port out_ones, width $clog2(WIDTH+1).
  - out_ones is the count of 1 bits in the result. It is computed at push time and stored alongside the result in the FIFO.
  - It is valid and stable under the same rules as out1, and resets to 0.
- When undefined:
  - The port and the storage are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then truth table with WIDTH=1 and op=00: push (0,0),(0,1),(1,0),(1,1) with out_ready=1 -> out1 sequence 0,0,0,1, each one cycle after its push, and ops_cnt=4.
- WIDTH=8: push in1=8'hF0, in2=8'h3C under ops 00,01,10,11 -> out1 = 8'h30, 8'hFC, 8'hCC, 8'hCF, in order.
- Backpressure: hold out_ready=0 and push 5 operand pairs with DEPTH=4 -> in_ready falls after the 4th push and the 5th is held. Raise out_ready -> 4 results drain in order, the 5th is accepted and emitted, and ops_cnt=5.
- Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, no result is lost or duplicated, and the output order matches the input order.
- Counter wrap with CNT_W=4: consume 17 results -> ops_cnt reads 1.
- Reset mid-operation: fill 3 entries, assert rst_n=0 for one edge -> out_valid=0, ops_cnt=0 and in_ready=1. The next push emits only the new result.
- With GATE_UNIT_POPCOUNT_EN defined: XOR of 8'hFF and 8'h0F -> out1=8'hF0, out_ones=4.
